// File: rtl/uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_param                                                              |
// | Oversampling UART receiver: N_BIT data bits, optional even/odd parity,     |
// | STOP_BITS stop bits. Reports parity, framing and break with each word.     |
// | Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on every bit.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_rx_param #(
    parameter int N_BIT     = 8,
    parameter int N_TICK    = 16,
    parameter int STOP_BITS = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             TICK,
    input  logic             RX,
    input  logic [1:0]       PARITY_MODE,
    output logic             RX_DONE,
    output logic [N_BIT-1:0] DOUT,
    output logic             PARITY_ERR,
    output logic             FRAME_ERR,
    output logic             BREAK,
    output logic [2:0]       STATE
);

    localparam int S_W = $clog2(N_TICK);
    localparam int N_W = $clog2(N_BIT);

    localparam logic [S_W-1:0] S_MID  = S_W'(N_TICK / 2 - 1);
    localparam logic [S_W-1:0] S_END  = S_W'(N_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(N_BIT - 1);
    localparam logic [N_W-1:0] N_STOP = N_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    state_t           state_q;
    logic             rx_meta_q;
    logic             rx_s_q;
    logic [S_W-1:0]   s_q;
    logic [N_W-1:0]   n_q;
    logic [N_BIT-1:0] b_q;
    logic [1:0]       mode_q;
    logic             par_err_q;
    logic             par_one_q;
    logic             ferr_q;
    logic             stop_one_q;

    logic w_bit;
    logic w_par_en;
    logic w_par_exp;
    logic w_ferr_nxt;
    logic w_stop_one_nxt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Holds rx_s from the two previous TICKs; since s advances by one per TICK
    // these are the samples taken at C-2 and C-1 when the decision is made at C.
    logic [1:0] hist_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hist_q <= 2'b11;
        end else if (TICK) begin
            hist_q <= {hist_q[0], rx_s_q};
        end
    end

    assign w_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
    assign w_bit = rx_s_q;
`endif

    assign w_par_en       = (mode_q == 2'b01) || (mode_q == 2'b10);
    assign w_par_exp      = (mode_q == 2'b10) ? ~^b_q : ^b_q;
    assign w_ferr_nxt     = ferr_q | ~w_bit;
    assign w_stop_one_nxt = stop_one_q | w_bit;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            n_q        <= '0;
            b_q        <= '0;
            mode_q     <= 2'b00;
            par_err_q  <= 1'b0;
            par_one_q  <= 1'b0;
            ferr_q     <= 1'b0;
            stop_one_q <= 1'b0;
            RX_DONE    <= 1'b0;
            DOUT       <= '0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
            BREAK      <= 1'b0;
        end else begin
            RX_DONE <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    mode_q <= PARITY_MODE;
                    if (!rx_s_q) begin
                        state_q <= ST_START;
                        s_q     <= '0;
                    end
                end

                ST_START: if (TICK) begin
                    if (s_q == S_MID) begin
                        if (!w_bit) begin
                            state_q    <= ST_DATA;
                            s_q        <= '0;
                            n_q        <= '0;
                            par_err_q  <= 1'b0;
                            par_one_q  <= 1'b0;
                            ferr_q     <= 1'b0;
                            stop_one_q <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        s_q <= s_q + S_W'(1);
                    end
                end

                ST_DATA: if (TICK) begin
                    if (s_q == S_END) begin
                        b_q <= {w_bit, b_q[N_BIT-1:1]};
                        s_q <= '0;
                        if (n_q == N_LAST) begin
                            n_q     <= '0;
                            state_q <= w_par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            n_q <= n_q + N_W'(1);
                        end
                    end else begin
                        s_q <= s_q + S_W'(1);
                    end
                end

                ST_PARITY: if (TICK) begin
                    if (s_q == S_END) begin
                        par_err_q <= w_bit ^ w_par_exp;
                        par_one_q <= w_bit;
                        s_q       <= '0;
                        n_q       <= '0;
                        state_q   <= ST_STOP;
                    end else begin
                        s_q <= s_q + S_W'(1);
                    end
                end

                ST_STOP: if (TICK) begin
                    if (s_q == S_END) begin
                        s_q        <= '0;
                        ferr_q     <= w_ferr_nxt;
                        stop_one_q <= w_stop_one_nxt;
                        if (n_q == N_STOP) begin
                            RX_DONE    <= 1'b1;
                            DOUT       <= b_q;
                            PARITY_ERR <= par_err_q;
                            FRAME_ERR  <= w_ferr_nxt;
                            BREAK      <= (b_q == '0) && !par_one_q && !w_stop_one_nxt;
                            n_q        <= '0;
                            state_q    <= w_ferr_nxt ? ST_WAIT_HIGH : ST_IDLE;
                        end else begin
                            n_q <= n_q + N_W'(1);
                        end
                    end else begin
                        s_q <= s_q + S_W'(1);
                    end
                end

                // A line held low must go high before another start is accepted.
                ST_WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign STATE = state_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx_param                                                           |
// | Self-checking bench: frame-level model of expected words, flags and timing.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_rx_param;

    localparam int N_BIT     = 8;
    localparam int N_TICK    = 16;
    localparam int STOP_BITS = 1;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             TICK = 1'b0;
    logic             RX = 1'b1;
    logic [1:0]       PARITY_MODE = 2'b00;
    logic             RX_DONE;
    logic [N_BIT-1:0] DOUT;
    logic             PARITY_ERR;
    logic             FRAME_ERR;
    logic             BREAK;
    logic [2:0]       STATE;

    uart_rx_param #(
        .N_BIT    (N_BIT),
        .N_TICK   (N_TICK),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .TICK       (TICK),
        .RX         (RX),
        .PARITY_MODE(PARITY_MODE),
        .RX_DONE    (RX_DONE),
        .DOUT       (DOUT),
        .PARITY_ERR (PARITY_ERR),
        .FRAME_ERR  (FRAME_ERR),
        .BREAK      (BREAK),
        .STATE      (STATE)
    );

    always #5 CLK = ~CLK;

    // One TICK every 4 CLKs.
    initial begin
        forever begin
            repeat (3) @(negedge CLK);
            TICK = 1'b1;
            @(negedge CLK);
            TICK = 1'b0;
        end
    end

    int tick_cnt = 0;
    always @(posedge CLK) if (TICK) tick_cnt <= tick_cnt + 1;

    typedef struct {
        logic [N_BIT-1:0] data;
        logic             perr;
        logic             ferr;
        logic             brk;
        int               len;
        int               start;
    } exp_t;

    exp_t expq[$];
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int sent_cnt = 0;

    logic [N_BIT-1:0] m_dout = '0;
    logic             m_perr = 1'b0;
    logic             m_ferr = 1'b0;
    logic             m_brk  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic par_bit(input logic [N_BIT-1:0] d, input logic [1:0] mode);
        int ones;
        ones = $countones(d);
        return (mode == 2'b10) ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    function automatic exp_t model(input logic [N_BIT-1:0] d, input logic [1:0] mode,
                                   input logic pbit, input logic [STOP_BITS-1:0] stops);
        exp_t m;
        logic pen;
        pen    = (mode == 2'b01) || (mode == 2'b10);
        m.data = d;
        m.perr = pen && (pbit != par_bit(d, mode));
        m.ferr = (stops != '1);
        m.brk  = (d == '0) && (!pen || !pbit) && (stops == '0);
        m.len  = N_TICK / 2 + N_TICK * (N_BIT + (pen ? 1 : 0) + STOP_BITS);
        m.start = 0;
        return m;
    endfunction

    // Compare process: checks every negedge against the frame-level model.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                m_dout = '0;
                m_perr = 1'b0;
                m_ferr = 1'b0;
                m_brk  = 1'b0;
                check("rx_done_in_reset", RX_DONE, 0);
            end
            if (!RESET && RX_DONE) begin
                done_cnt++;
                if (expq.size() == 0) begin
                    check("spurious_rx_done", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("dout", DOUT, e.data);
                    check("parity_err", PARITY_ERR, e.perr);
                    check("frame_err", FRAME_ERR, e.ferr);
                    check("break", BREAK, e.brk);
                    check("done_tick_latency", tick_cnt - e.start, e.len);
                    m_dout = e.data;
                    m_perr = e.perr;
                    m_ferr = e.ferr;
                    m_brk  = e.brk;
                end
            end else begin
                check("dout_hold", DOUT, m_dout);
                check("parity_err_hold", PARITY_ERR, m_perr);
                check("frame_err_hold", FRAME_ERR, m_ferr);
                check("break_hold", BREAK, m_brk);
            end
        end
    end

    task automatic wait_tick();
        @(posedge CLK);
        while (TICK !== 1'b1) @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) wait_tick();
    endtask

    task automatic send_bit(input logic v, input logic glitch);
        RX = v;
        if (glitch) begin
            repeat (N_TICK / 2 - 1) wait_tick();
            RX = ~v;
            wait_tick();
            RX = v;
            repeat (N_TICK / 2) wait_tick();
        end else begin
            repeat (N_TICK) wait_tick();
        end
    endtask

    // Must be called right after a TICK; returns right after a TICK.
    task automatic send_frame(input logic [N_BIT-1:0] d, input logic [1:0] mode, input logic pbit,
                              input logic [STOP_BITS-1:0] stops, input int glitch_bit);
        exp_t e;
        PARITY_MODE = mode;
        e = model(d, mode, pbit, stops);
        e.start = tick_cnt;
        expq.push_back(e);
        sent_cnt++;
        send_bit(1'b0, 1'b0);
        PARITY_MODE = 2'($urandom_range(0, 3));
        for (int i = 0; i < N_BIT; i++) send_bit(d[i], i == glitch_bit);
        if (mode == 2'b01 || mode == 2'b10) send_bit(pbit, 1'b0);
        for (int i = 0; i < STOP_BITS; i++) send_bit(stops[i], 1'b0);
    endtask

    initial begin
        int d0;
        logic [N_BIT-1:0] d;
        logic [1:0] mode;
        logic pbit;
        logic [STOP_BITS-1:0] stops;

        repeat (5) @(posedge CLK);
        #1;
        check("reset_state", STATE, 0);
        check("reset_rx_done", RX_DONE, 0);
        check("reset_dout", DOUT, 0);
        check("reset_flags", {PARITY_ERR, FRAME_ERR, BREAK}, 0);
        RESET = 1'b0;
        idle(4);

        // 8N1 0x55
        d0 = done_cnt;
        send_frame(8'h55, 2'b00, 1'b0, '1, -1);
        check("n1_dout", DOUT, 8'h55);
        check("n1_flags", {PARITY_ERR, FRAME_ERR, BREAK}, 3'b000);
        check("n1_done_count", done_cnt - d0, 1);
        check("n1_state", STATE, 0);

        // Even parity 0xA3 (four ones, parity bit should be 0)
        send_frame(8'hA3, 2'b01, 1'b1, '1, -1);
        check("even_bad_perr", PARITY_ERR, 1);
        check("even_bad_ferr", FRAME_ERR, 0);
        check("even_bad_dout", DOUT, 8'hA3);
        send_frame(8'hA3, 2'b01, 1'b0, '1, -1);
        check("even_good_perr", PARITY_ERR, 0);

        // False start
        d0 = done_cnt;
        RX = 1'b0;
        repeat (N_TICK / 4) wait_tick();
        idle(2 * N_TICK);
        check("false_start_state", STATE, 0);
        check("false_start_no_done", done_cnt - d0, 0);

        // Framing error, line held low
        send_frame(8'h3C, 2'b00, 1'b0, '0, -1);
        RX = 1'b0;
        repeat (N_TICK) wait_tick();
        check("ferr_flag", FRAME_ERR, 1);
        check("ferr_dout", DOUT, 8'h3C);
        check("ferr_wait_high", STATE, 5);
        idle(2);
        check("ferr_back_idle", STATE, 0);
        idle(N_TICK);

        // Break: line low for 3 frame times
        d0 = done_cnt;
        send_frame('0, 2'b00, 1'b0, '0, -1);
        RX = 1'b0;
        repeat (2 * N_TICK * (N_BIT + 2)) wait_tick();
        check("break_one_done", done_cnt - d0, 1);
        check("break_dout", DOUT, 0);
        check("break_flags", {FRAME_ERR, BREAK}, 2'b11);
        check("break_wait_high", STATE, 5);
        idle(N_TICK);

        // Reset in the middle of DATA
        RX = 1'b0;
        repeat (N_TICK * 3) wait_tick();
        RX = 1'b1;
        repeat (N_TICK) wait_tick();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        idle(N_TICK);
        check("midreset_state", STATE, 0);
        check("midreset_dout", DOUT, 0);
        send_frame(8'h81, 2'b00, 1'b0, '1, -1);
        check("after_reset_dout", DOUT, 8'h81);
        check("after_reset_flags", {PARITY_ERR, FRAME_ERR, BREAK}, 3'b000);

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h5A, 2'b00, 1'b0, '1, 3);
        check("glitch_dout", DOUT, 8'h5A);
`endif

        // Random frames, mostly back-to-back
        for (int k = 0; k < 24; k++) begin
            d     = N_BIT'($urandom);
            mode  = 2'($urandom_range(0, 3));
            pbit  = par_bit(d, mode) ^ ($urandom_range(0, 3) == 0);
            stops = ($urandom_range(0, 5) == 0) ? '0 : '1;
            send_frame(d, mode, pbit, stops, -1);
            if (stops != '1) idle(N_TICK);
            else idle($urandom_range(0, 2) * (N_TICK / 2));
        end

        idle(2 * N_TICK);
        check("queue_drained", expq.size(), 0);
        check("done_total", done_cnt, sent_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
